// File: rtl/tmr0_wdt_psc.sv
// ---------------------------------------------------------------------------
// tmr0_wdt_psc
//
// Timer/watchdog peripheral that sits beside the PIC16F54 core. It turns the
// core's OPTION register and strobes plus the external T0CKI pin into the
// core's TMR0 increment and watchdog time-out pulses.
//
// Blocks:
//   - T0CKI synchroniser (three flops) with selectable edge detect
//   - watchdog base divider (period WDT_BASE clk cycles)
//   - single 8-bit prescaler, assigned to TMR0 (PSA=0) or to the WDT (PSA=1)
//
// Handshake: there is no valid/ready flow control. Every output is a
// registered level sampled once per clk; tmr0_inc and wdtmr are single-cycle
// pulses, and psc_q is the live prescaler count.
//
// Ports:
//   clk       in   system clock, one core instruction cycle per clk
//   rst       in   asynchronous active-low reset
//   option    in   [5] T0CS, [4] T0SE, [3] PSA, [2:0] PS (bits [7:6] unused)
//   t0cki     in   external TMR0 clock pin, asynchronous to clk
//   wdt_en    in   watchdog enable fuse (static)
//   clrwdt    in   one-cycle pulse, core executing CLRWDT
//   sleep     in   one-cycle pulse, core executing SLEEP
//   tmr0_wr   in   one-cycle pulse, core writing TMR0
//   tmr0_inc  out  one-cycle pulse: increment TMR0
//   wdtmr     out  one-cycle pulse: watchdog time-out
//   psc_q     out  current prescaler count
// ---------------------------------------------------------------------------
module tmr0_wdt_psc #(
    parameter int WDT_BASE = 256,
    parameter int WDT_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] option,
    input  logic       t0cki,
    input  logic       wdt_en,
    input  logic       clrwdt,
    input  logic       sleep,
    input  logic       tmr0_wr,
    output logic       tmr0_inc,
    output logic       wdtmr,
    output logic [7:0] psc_q
);

    localparam logic [WDT_W-1:0] DIV_LAST = WDT_W'(WDT_BASE - 1);

    // OPTION fields
    logic       w_t0cs;
    logic       w_t0se;
    logic       w_psa;
    logic [2:0] w_ps;
    logic [1:0] w_unused_opt;

    assign w_t0cs       = option[5];
    assign w_t0se       = option[4];
    assign w_psa        = option[3];
    assign w_ps         = option[2:0];
    assign w_unused_opt = option[7:6];

    // Registers
    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [WDT_W-1:0] r_wdt_div;
    logic             r_psa;
    logic [7:0]       r_psc;
    logic             r_tmr0_inc;
    logic             r_wdtmr;

    // Combinational helpers
    logic       w_pin_ev;
    logic       w_src_ev;
    logic       w_base_tick;
    logic       w_wdt_clr;
    logic       w_psc_clr;
    logic [7:0] w_mask;
    logic       w_psc_hit;

    // s1 is the metastability catcher; edges are detected between s2 and s3
    // so only settled levels feed the logic.
    assign w_pin_ev = w_t0se ? (r_s3 & ~r_s2) : (r_s2 & ~r_s3);
    assign w_src_ev = w_t0cs ? w_pin_ev : 1'b1;

    assign w_base_tick = wdt_en & (r_wdt_div == DIV_LAST);
    assign w_wdt_clr   = clrwdt | sleep;

    // Prescaler clear sources depend on which side owns the prescaler; a
    // change of ownership always restarts the count.
    assign w_psc_clr = (tmr0_wr & ~w_psa)
                     | (w_wdt_clr & w_psa)
                     | (w_psa != r_psa);

    // Terminal count: 2^(PS+1)-1 for TMR0, 2^PS-1 for the watchdog.
    // Shifting an all-ones byte avoids the 9-bit overflow of 2<<7.
    assign w_mask = w_psa ? (8'hFF >> (4'd8 - {1'b0, w_ps}))
                          : (8'hFF >> (4'd7 - {1'b0, w_ps}));

    // A count above a freshly lowered mask simply runs on and wraps through 0.
    assign w_psc_hit = (r_psc == w_mask);

    // T0CKI synchroniser
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= t0cki;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Watchdog base divider
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdt_div <= '0;
        end else if (!wdt_en || w_wdt_clr || (r_wdt_div == DIV_LAST)) begin
            r_wdt_div <= '0;
        end else begin
            r_wdt_div <= r_wdt_div + WDT_W'(1);
        end
    end

    // Prescaler and output pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_psa      <= 1'b0;
            r_psc      <= 8'd0;
            r_tmr0_inc <= 1'b0;
            r_wdtmr    <= 1'b0;
        end else begin
            r_psa      <= w_psa;
            r_tmr0_inc <= 1'b0;
            r_wdtmr    <= 1'b0;
            if (!w_psa) begin
                // Prescaler on TMR0; watchdog runs straight off the base tick.
                r_wdtmr <= w_base_tick & ~w_wdt_clr;
                if (w_psc_clr) begin
                    r_psc <= 8'd0;
                end else if (w_src_ev) begin
                    if (w_psc_hit) begin
                        r_psc      <= 8'd0;
                        r_tmr0_inc <= 1'b1;
                    end else begin
                        r_psc <= r_psc + 8'd1;
                    end
                end
            end else begin
                // Prescaler on the watchdog; TMR0 follows every source event.
                r_tmr0_inc <= w_src_ev;
                if (w_psc_clr) begin
                    r_psc <= 8'd0;
                end else if (w_base_tick) begin
                    if (w_psc_hit) begin
                        r_psc   <= 8'd0;
                        r_wdtmr <= 1'b1;
                    end else begin
                        r_psc <= r_psc + 8'd1;
                    end
                end
            end
        end
    end

    assign tmr0_inc = r_tmr0_inc;
    assign wdtmr    = r_wdtmr;
    assign psc_q    = r_psc;

endmodule

// File: doc/tmr0_wdt_psc.md
Name: tmr0_wdt_psc

Overview:
- Peripheral counterpart to the PIC16F54 core's timer/watchdog interface.
- Consumes the core's OPTION register, CLRWDT, SLEEP and TMR0-write strobes, plus the external T0CKI pin.
- Produces the core's tmr0_inc and wdtmr inputs.
- Contains the T0CKI synchroniser/edge selector, the shared 8-bit prescaler and the watchdog base divider; sits beside the core in the top level.

Parameters:
- WDT_BASE, 256, clk cycles per un-prescaled watchdog base tick (>=2).
- WDT_W, 16, width of the watchdog base divider; must satisfy 2^WDT_W >= WDT_BASE.

Ports:
- clk  in  1  system clock; one core instruction cycle per clk.
- rst  in  1  reset, asynchronous, active-low.
- option  in  8  core OPTION register: [5] T0CS, [4] T0SE, [3] PSA, [2:0] PS.
- t0cki  in  1  external TMR0 clock pin, asynchronous to clk.
- wdt_en  in  1  watchdog enable (configuration fuse), static.
- clrwdt  in  1  one-cycle pulse, core executing CLRWDT.
- sleep  in  1  one-cycle pulse, core executing SLEEP.
- tmr0_wr  in  1  one-cycle pulse, core writing TMR0.
- tmr0_inc  out  1  one-cycle registered pulse: increment TMR0.
- wdtmr  out  1  one-cycle registered pulse: watchdog time-out.
- psc_q  out  8  current prescaler count (debug/verification).

Behaviour:
- Reset (rst=0, asynchronous): tmr0_inc=0, wdtmr=0, psc_q=0, base divider=0, sync flops s1/s2/s3=0, stored PSA copy=0.
- Reset takes effect immediately, including mid-count. All state resumes from zero on the first clk after rst rises.
- **T0CKI path:** three-flop chain s1<-t0cki, s2<-s1, s3<-s2.
  - pin_ev = s2&~s3 when T0SE=0 (rising edge); s3&~s2 when T0SE=1 (falling edge).
  - Latency: if the new pin level is first sampled at edge k, tmr0_inc is high after edge k+2 (PSA=1).
  - Edges narrower than one clk period may be lost; no requirement on them.
- **Source event:** src_ev = pin_ev when T0CS=1, else 1 every cycle.
- **Watchdog base divider:**
  - When wdt_en=1: counts 0..WDT_BASE-1 and wraps. base_tick=1 in the cycle the count equals WDT_BASE-1.
  - When wdt_en=0: held at 0 and wdtmr never asserts.
- **Prescaler:** single 8-bit counter psc_q, assigned by PSA.
  - PSA=0 (assigned to TMR0): mask=(2<<PS)-1, giving ratio 1:2..1:256.
    - On src_ev: if psc_q==mask, psc_q<=0 and tmr0_inc<=1; else psc_q<=psc_q+1.
    - wdtmr<=base_tick&wdt_en (watchdog runs un-prescaled).
  - PSA=1 (assigned to WDT): tmr0_inc<=src_ev (ratio 1:1).
    - mask=(1<<PS)-1, giving ratio 1:1..1:128.
    - On base_tick: if psc_q==mask, psc_q<=0 and wdtmr<=1; else psc_q<=psc_q+1.
  - Both pulse outputs default to 0 each cycle unless set as above.
- **Prescaler clear:** psc_q<=0 on any of:
  - tmr0_wr while PSA=0;
  - clrwdt or sleep while PSA=1;
  - any change of PSA (compared against the stored copy, updated every cycle).
- Clear has priority over a simultaneous count event. The event is dropped: no pulse, no increment.
- **Watchdog clear:** clrwdt or sleep also sets the base divider to 0 and suppresses wdtmr in that cycle.
- **PS change:** takes effect on the next compare. If psc_q already exceeds the new mask, the count runs on to 255, wraps to 0, and the next compare then matches.
- The watchdog keeps counting during sleep. Wake-up is the core's responsibility.
- tmr0_inc and wdtmr are never asserted for more than one cycle per qualifying event. tmr0_inc may be high on consecutive cycles only when the ratio is 1:1.

Test Plan:
- Internal source at 1:1: rst low then high; option=8'h08 (T0CS=0, PSA=1) -> tmr0_inc=1 from the first cycle after reset and every cycle thereafter; psc_q stays 0.
- Internal source prescaled: option=8'h02 (PSA=0, PS=2, 1:8) -> tmr0_inc pulses once every 8 cycles; psc_q cycles 0..7. Pulse tmr0_wr at psc_q=5 -> psc_q=0 next cycle and the next pulse arrives 8 cycles later.
- External falling edge: option=8'h38 (T0CS=1, T0SE=1, PSA=1); drive t0cki 1->0 sampled at edge k -> tmr0_inc high exactly one cycle, after edge k+2. A rising edge produces no pulse.
- WDT prescaled: WDT_BASE=4, wdt_en=1, option=8'h0B (PSA=1, PS=3, 1:8) -> first wdtmr pulse after 32 cycles, then every 32 cycles. clrwdt at cycle 20 -> next wdtmr 32 cycles after the clrwdt.
- PSA switch and simultaneity: with psc_q=3, change option 8'h02->8'h0A -> psc_q=0 next cycle. With PSA=0, tmr0_wr coincident with the terminal src_ev -> no tmr0_inc, psc_q=0.
- Async reset mid-count: assert rst low between clk edges at psc_q=6 -> psc_q, tmr0_inc and wdtmr are 0 immediately. wdt_en=0 for 10000 cycles -> wdtmr never 1.
